// File: rtl/pwm_pkg.sv
// Shared constants and types for the LED PWM encoder/decoder pair.
// Both ends take the PWM period, timeout and counter widths from here.
package pwm_pkg;

    localparam int PWM_PERIOD  = 10;
    localparam int PWM_TIMEOUT = 20;
    localparam int LEVEL_W     = 4;
    localparam int CNT_W       = 5;

    typedef enum logic {
        S_IDLE,
        S_MEAS
    } state_t;

    // Decoder event captured on the detecting clock, emitted one clock later
    typedef enum logic [1:0] {
        EV_NONE,
        EV_GOOD,
        EV_ERR,
        EV_TOUT
    } evt_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a history flop;
// rise_o is high for one clock when the synchronized level goes 0 -> 1.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~hist_q;

endmodule

// File: rtl/pwm_level_decoder.sv
// Recovers the intensity level from an LED PWM waveform by counting high
// cycles between rising edges; a missing edge reports a constant 0 or full level.
module pwm_level_decoder
    import pwm_pkg::*;
#(
    parameter int PERIOD  = PWM_PERIOD,
    parameter int TIMEOUT = PWM_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pwm_in,
    output logic [LEVEL_W-1:0] level,
    output logic               level_valid,
    output logic               period_err,
    output logic               locked
);

    localparam logic [CNT_W-1:0]   PER_C  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0]   TOUT_C = CNT_W'(TIMEOUT);
    localparam logic [LEVEL_W-1:0] FULL_C = LEVEL_W'(PERIOD);

    logic               sync;
    logic               rise;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   per_q, per_d;
    logic [LEVEL_W-1:0] hi_q, hi_d;
    evt_t               evt_q, evt_d;
    logic [LEVEL_W-1:0] cap_q, cap_d;

    logic [LEVEL_W-1:0] level_q;
    logic               valid_q;
    logic               err_q;
    logic               locked_q;

    sync_edge_det u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (pwm_in),
        .sync_o (sync),
        .rise_o (rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A rising edge wins over a timeout landing on the same clock
    always_comb begin
        state_d = state_q;
        if (rise) begin
            state_d = S_MEAS;
        end else if (state_q == S_MEAS && per_q == TOUT_C) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        per_d = sat_inc(per_q, TOUT_C);
        hi_d  = hi_q;
        if (sync && hi_q < FULL_C) begin
            hi_d = hi_q + 1'b1;
        end
        evt_d = EV_NONE;
        cap_d = cap_q;
        if (rise) begin
            per_d = CNT_W'(1);
            hi_d  = LEVEL_W'(1);
            if (state_q == S_MEAS) begin
                evt_d = (per_q == PER_C) ? EV_GOOD : EV_ERR;
                cap_d = hi_q;
            end
        end else if (state_q == S_MEAS && per_q == TOUT_C) begin
            per_d = '0;
            hi_d  = '0;
            evt_d = EV_TOUT;
            cap_d = sync ? FULL_C : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_q <= '0;
            hi_q  <= '0;
            evt_q <= EV_NONE;
            cap_q <= '0;
        end else begin
            per_q <= per_d;
            hi_q  <= hi_d;
            evt_q <= evt_d;
            cap_q <= cap_d;
        end
    end

    // Output register: events surface one clock after detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            valid_q <= (evt_q == EV_GOOD) || (evt_q == EV_TOUT);
            err_q   <= (evt_q == EV_ERR);
            case (evt_q)
                EV_GOOD: begin
                    level_q  <= cap_q;
                    locked_q <= 1'b1;
                end
                EV_ERR: begin
                    locked_q <= 1'b0;
                end
                EV_TOUT: begin
                    level_q  <= cap_q;
                    locked_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign level       = level_q;
    assign level_valid = valid_q;
    assign period_err  = err_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_pwm_level_decoder.sv
// Directed bench for pwm_level_decoder: a table of PWM segments with expected
// event counts, followed by timeout, edge-on-timeout and reset sequences.
module tb_pwm_level_decoder;

    logic       clk;
    logic       rst;
    logic       pwm_in;
    logic [3:0] level;
    logic       level_valid;
    logic       period_err;
    logic       locked;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;
    int last_valid_cyc = 0;
    int last_edge_cyc = 0;

    typedef struct {
        int h;
        int p;
        int n;
        int exp_valid;
        int exp_err;
        int exp_level;
        int exp_locked;
    } row_t;

    row_t rows[6];

    pwm_level_decoder #(.PERIOD(10), .TIMEOUT(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .level       (level),
        .level_valid (level_valid),
        .period_err  (period_err),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (level_valid) begin
            n_valid <= n_valid + 1;
            last_valid_cyc <= cyc;
        end
        if (period_err) n_err <= n_err + 1;
        if (level_valid && period_err) n_both <= n_both + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_period(input int h, input int p);
        for (int i = 0; i < p; i++) begin
            pwm_in = (i < h);
            if (i == 0) last_edge_cyc = cyc;
            tick();
        end
    endtask

    task automatic drive_const(input logic v, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            pwm_in = v;
            tick();
        end
    endtask

    initial begin
        int v0;
        int e0;

        rows[0] = '{h: 3, p: 10, n: 5, exp_valid: 4, exp_err: 0, exp_level: 3, exp_locked: 1};
        rows[1] = '{h: 7, p: 10, n: 3, exp_valid: 3, exp_err: 0, exp_level: 7, exp_locked: 1};
        rows[2] = '{h: 2, p: 10, n: 3, exp_valid: 3, exp_err: 0, exp_level: 2, exp_locked: 1};
        rows[3] = '{h: 4, p: 8,  n: 1, exp_valid: 1, exp_err: 0, exp_level: 2, exp_locked: 1};
        rows[4] = '{h: 5, p: 10, n: 1, exp_valid: 0, exp_err: 1, exp_level: 2, exp_locked: 0};
        rows[5] = '{h: 5, p: 10, n: 2, exp_valid: 2, exp_err: 0, exp_level: 5, exp_locked: 1};

        rst = 1'b1;
        pwm_in = 1'b0;
        repeat (3) tick();
        chk("reset_level", level, 0);
        chk("reset_valid", level_valid, 0);
        chk("reset_err", period_err, 0);
        chk("reset_locked", locked, 0);
        rst = 1'b0;
        drive_const(1'b0, 4);
        chk("idle_level", level, 0);

        for (int r = 0; r < 6; r++) begin
            v0 = n_valid;
            e0 = n_err;
            for (int k = 0; k < rows[r].n; k++) drive_period(rows[r].h, rows[r].p);
            chk($sformatf("row%0d_valids", r), n_valid - v0, rows[r].exp_valid);
            chk($sformatf("row%0d_errs", r), n_err - e0, rows[r].exp_err);
            chk($sformatf("row%0d_level", r), level, rows[r].exp_level);
            chk($sformatf("row%0d_locked", r), locked, rows[r].exp_locked);
            if (rows[r].exp_valid > 0 && rows[r].exp_err == 0)
                chk($sformatf("row%0d_latency", r), last_valid_cyc - last_edge_cyc, 4);
        end

        // constant low after lock
        v0 = n_valid;
        e0 = n_err;
        drive_const(1'b0, 25);
        chk("tout_low_valids", n_valid - v0, 1);
        chk("tout_low_errs", n_err - e0, 0);
        chk("tout_low_level", level, 0);
        chk("tout_low_locked", locked, 0);

        // constant high
        v0 = n_valid;
        e0 = n_err;
        drive_const(1'b1, 28);
        chk("tout_high_valids", n_valid - v0, 1);
        chk("tout_high_errs", n_err - e0, 0);
        chk("tout_high_level", level, 10);
        chk("tout_high_locked", locked, 0);

        // second edge lands exactly on the timeout cycle
        drive_const(1'b0, 3);
        v0 = n_valid;
        e0 = n_err;
        drive_period(3, 20);
        drive_period(3, 10);
        chk("edge_on_tout_valids", n_valid - v0, 0);
        chk("edge_on_tout_errs", n_err - e0, 1);
        chk("edge_on_tout_level", level, 10);
        chk("edge_on_tout_locked", locked, 0);

        // reset mid-measurement
        for (int k = 0; k < 3; k++) drive_period(3, 10);
        chk("prereset_locked", locked, 1);
        chk("prereset_level", level, 3);
        drive_const(1'b1, 2);
        rst = 1'b1;
        pwm_in = 1'b0;
        #1;
        chk("midrst_level", level, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_valid", level_valid, 0);
        chk("midrst_err", period_err, 0);
        repeat (3) tick();
        rst = 1'b0;
        drive_const(1'b0, 2);
        v0 = n_valid;
        e0 = n_err;
        drive_period(3, 10);
        chk("postrst_edge1_valids", n_valid - v0, 0);
        chk("postrst_edge1_errs", n_err - e0, 0);
        v0 = n_valid;
        drive_period(3, 10);
        chk("postrst_edge2_valids", n_valid - v0, 1);
        chk("postrst_level", level, 3);
        chk("postrst_locked", locked, 1);

        chk("valid_err_exclusive", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
